// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// control-level constants used by the EX stage and the stall controller.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic RST_ENABLE           = 1'b1;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic STALLREQ_ENABLE      = 1'b1;
  localparam logic STALLREQ_DISABLE     = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring shift-subtract iteration.
//   rem, quo, divisor  current partial remainder, quotient/dividend shifter, divisor
//   rem_next, quo_next state after shifting {rem,quo} left and trying the subtract
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  // One extra bit so the shifted remainder and the subtract never overflow;
  // trial[DATA_W] acts as the borrow (set = trial negative).
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[DATA_W]) begin
      rem_next = trial[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 DIV/DIVU for the EX stage. Runs DATA_W restoring
// steps and holds a stall request until the {HI,LO} result is ready.
//   clk, rst          clock, asynchronous active-high reset
//   signed_div_i      1 = signed DIV, 0 = DIVU
//   opdata1_i/2_i     dividend / divisor, sampled only when leaving IDLE
//   start_i, annul_i  request (held until ready_o), flush (kills operation)
//   result_o          {remainder, quotient}
//   ready_o           result_o valid
//   stallreq_o        stall request to the pipeline controller
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  div_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem, quo, divisor;
  logic              neg_quo, neg_rem;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] fin_rem, fin_quo;
  logic [DATA_W-1:0] abs_op1, abs_op2;
  logic              div_by_zero;
  logic              last_step;

  assign abs_op1     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs_op2     = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign div_by_zero = (opdata2_i == '0);
  assign last_step   = (cnt == CNT_W'(DATA_W - 1));

  // Fix-up is applied to the final step's output so the result can be
  // registered on the ON->END edge and ready_o is valid in the first END cycle.
  assign fin_quo = neg_quo ? -step_quo : step_quo;
  assign fin_rem = neg_rem ? -step_rem : step_rem;

  assign stallreq_o = (start_i & ~ready_o & ~annul_i) ? STALLREQ_ENABLE : STALLREQ_DISABLE;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_next = state;
    if (annul_i) begin
      state_next = DIV_FREE;
    end else begin
      case (state)
        DIV_FREE:   if (start_i == DIV_START) state_next = div_by_zero ? DIV_BYZERO : DIV_ON;
        DIV_BYZERO: state_next = DIV_END;
        DIV_ON:     if (last_step) state_next = DIV_END;
        DIV_END:    if (start_i == DIV_STOP) state_next = DIV_FREE;
        default:    state_next = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state <= state_next;
      if (annul_i) begin
        result_o <= '0;
        ready_o  <= DIV_RESULT_NOT_READY;
      end else begin
        case (state)
          DIV_FREE: begin
            if (start_i == DIV_START) begin
              rem     <= '0;
              cnt     <= '0;
              divisor <= abs_op2;
              neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
              // Divide-by-zero returns the raw dividend as remainder, so keep it unsigned-untouched.
              quo     <= div_by_zero ? opdata1_i : abs_op1;
            end
          end
          DIV_BYZERO: begin
            result_o <= {quo, {DATA_W{1'b1}}};
            ready_o  <= DIV_RESULT_READY;
          end
          DIV_ON: begin
            rem <= step_rem;
            quo <= step_quo;
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
              result_o <= {fin_rem, fin_quo};
              ready_o  <= DIV_RESULT_READY;
            end
          end
          DIV_END: begin
            if (start_i == DIV_STOP) begin
              result_o <= '0;
              ready_o  <= DIV_RESULT_NOT_READY;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  // Full divide with start held; operands are scrambled after they are sampled.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_stall);
    int stalls;
    bit done;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    #1;
    stalls = 0; done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ready_o === 1'b1) begin done = 1'b1; break; end
      if (stallreq_o === 1'b1) stalls++;
      @(negedge clk); #1;
      if (i == 0) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
      end
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL %s timeout: ready=%b required 1", name, ready_o); end
    n_cmp++;
    if (stalls !== exp_stall) begin
      n_err++; $display("FAIL %s stall_cycles: got %0d required %0d", name, stalls, exp_stall);
    end
    n_cmp++;
    if (result_o !== exp_res) begin
      n_err++; $display("FAIL %s result: got %h required %h", name, result_o, exp_res);
    end
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_err++; $display("FAIL %s stall_when_ready: got %b required 0", name, stallreq_o);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (ready_o !== 1'b1 || result_o !== exp_res) begin
      n_err++; $display("FAIL %s hold_in_end: ready=%b result=%h required 1 %h", name, ready_o, result_o, exp_res);
    end
    start_i = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++; $display("FAIL %s clear: ready=%b result=%h required 0 0", name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #12;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: ready=%b result=%h stall=%b required 0 0 0", ready_o, result_o, stallreq_o);
    end
    start_i = 1'b1; #1;
    n_cmp++;
    if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL reset_stall_start: got %b required 1", stallreq_o); end
    annul_i = 1'b1; #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stall_annul: got %b required 0", stallreq_o); end
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_div("divu_100_7",   1'b0, 32'd100,       32'd7,         {32'h2, 32'hE},               33);
    run_div("divu_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         {32'h0, 32'hFFFFFFFF},        33);
    run_div("divu_big_div", 1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000, 32'h0},        33);
    run_div("divu_3q",      1'b0, 32'hFFFFFFFF,  32'h40000001,  {32'h3FFFFFFC, 32'h3},        33);
  endtask

  task automatic test_signed();
    run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("div_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  {32'h1, 32'hFFFFFFFD},        33);
    run_div("div_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000},        33);
  endtask

  task automatic test_div_zero();
    run_div("divu_5_0",     1'b0, 32'd5,         32'd0,         {32'h5, 32'hFFFFFFFF},        2);
    run_div("div_m3_0",     1'b1, 32'hFFFFFFFD,  32'd0,         {32'hFFFFFFFD, 32'hFFFFFFFF}, 2);
  endtask

  task automatic test_annul();
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1; annul_i = 1'b1; #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL annul_stall: got %b required 0", stallreq_o); end
    @(negedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0; #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin
      n_err++; $display("FAIL annul_idle: ready=%b result=%h stall=%b required 0 0 0", ready_o, result_o, stallreq_o);
    end
    run_div("after_annul", 1'b0, 32'd1000, 32'd10, {32'h0, 32'h64}, 33);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #2; rst = 1'b1; #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b1) begin
      n_err++; $display("FAIL reset_mid: ready=%b result=%h stall=%b required 0 0 1", ready_o, result_o, stallreq_o);
    end
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    // Async reset while a finished result is being held.
    @(negedge clk);
    opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2; rst = 1'b1; #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_err++; $display("FAIL reset_in_end: ready=%b result=%h required 0 0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_div("after_reset", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
